// File: rtl/period_stats.sv
// period_stats
// ------------
// Edge-interval statistics for the clock-measurement path. Every code_edge
// pulse is timestamped against clk. Over a fixed window of WIN_CYCLES cycles
// the block gathers the longest and shortest edge-to-edge interval, the
// number of edges and whether any interval saturated the counter. At each
// window close the results are registered and announced by a one-cycle
// result_valid strobe.
//
// Parameters:
//   CNT_W      width of the interval counter and of max_period/min_period
//   WIN_CYCLES window length in clk cycles (2 .. 2^24-1)
//   EDGE_W     width of edge_count
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   code_edge    single-cycle edge pulse, synchronous to clk
//   max_period   longest interval of the last closed window (cycles)
//   min_period   shortest interval of the last closed window, 0 if none
//   edge_count   edges seen in the last closed window, saturating
//   overflow     an interval of the last closed window hit saturation
//   result_valid one-cycle pulse in the cycle the outputs update

module period_stats #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WIN_CYCLES = 10000,
    parameter int unsigned EDGE_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_edge,
    output logic [CNT_W-1:0]  max_period,
    output logic [CNT_W-1:0]  min_period,
    output logic [EDGE_W-1:0] edge_count,
    output logic              overflow,
    output logic              result_valid
);

    // The window counter is sized for the largest legal window length.
    localparam int unsigned       WIN_W    = 24;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
    localparam logic [EDGE_W-1:0] EDGE_SAT = '1;

    logic [WIN_W-1:0]  win_cnt_q,      win_cnt_d;
    logic [CNT_W-1:0]  cnt_q,          cnt_d;
    logic              seen_q,         seen_d;
    logic [CNT_W-1:0]  acc_max_q,      acc_max_d;
    logic [CNT_W-1:0]  acc_min_q,      acc_min_d;
    logic [EDGE_W-1:0] acc_edges_q,    acc_edges_d;
    logic              acc_ovf_q,      acc_ovf_d;
    logic              acc_n_q,        acc_n_d;
    logic [CNT_W-1:0]  max_period_q,   max_period_d;
    logic [CNT_W-1:0]  min_period_q,   min_period_d;
    logic [EDGE_W-1:0] edge_count_q,   edge_count_d;
    logic              overflow_q,     overflow_d;
    logic              result_valid_q, result_valid_d;

    logic              win_close;
    logic              sample_vld;
    logic [CNT_W-1:0]  mrg_max;
    logic [CNT_W-1:0]  mrg_min;
    logic [EDGE_W-1:0] mrg_edges;
    logic              mrg_ovf;
    logic              mrg_n;

    // Window timing and the free-running interval counter. The interval
    // counter reloads with 1 on an edge so that the value it holds on the
    // next edge equals the distance between the two edges in cycles. It is
    // deliberately not cleared at window boundaries so intervals spanning a
    // boundary are measured correctly.
    always_comb begin
        win_close  = (win_cnt_q == WIN_LAST);
        sample_vld = code_edge && seen_q;

        win_cnt_d = win_close ? '0 : win_cnt_q + WIN_W'(1);
        seen_d    = seen_q | code_edge;

        if (code_edge) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Accumulator contents with the current cycle's edge folded in. These
    // merged values feed both the accumulators and, on the close cycle, the
    // output registers, so an edge on the close cycle belongs to the window
    // being closed.
    always_comb begin
        mrg_max   = acc_max_q;
        mrg_min   = acc_min_q;
        mrg_edges = acc_edges_q;
        mrg_ovf   = acc_ovf_q;
        mrg_n     = acc_n_q;

        if (sample_vld) begin
            if (cnt_q > acc_max_q) begin
                mrg_max = cnt_q;
            end
            if (cnt_q < acc_min_q) begin
                mrg_min = cnt_q;
            end
            if (cnt_q == CNT_SAT) begin
                mrg_ovf = 1'b1;
            end
            mrg_n = 1'b1;
        end

        if (code_edge && (acc_edges_q != EDGE_SAT)) begin
            mrg_edges = acc_edges_q + EDGE_W'(1);
        end
    end

    // Window close: publish the merged statistics and restart the
    // accumulators empty. Between closes the outputs simply hold.
    always_comb begin
        max_period_d   = max_period_q;
        min_period_d   = min_period_q;
        edge_count_d   = edge_count_q;
        overflow_d     = overflow_q;
        result_valid_d = win_close;

        acc_max_d   = mrg_max;
        acc_min_d   = mrg_min;
        acc_edges_d = mrg_edges;
        acc_ovf_d   = mrg_ovf;
        acc_n_d     = mrg_n;

        if (win_close) begin
            max_period_d = mrg_max;
            // A window without any interval reports 0 rather than all-ones.
            min_period_d = mrg_n ? mrg_min : '0;
            edge_count_d = mrg_edges;
            overflow_d   = mrg_ovf;

            acc_max_d   = '0;
            acc_min_d   = CNT_SAT;
            acc_edges_d = '0;
            acc_ovf_d   = 1'b0;
            acc_n_d     = 1'b0;
        end
    end

    // State register. Reset discards any partial window and forgets the
    // last edge, so the first edge afterwards produces no interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q      <= '0;
            cnt_q          <= '0;
            seen_q         <= 1'b0;
            acc_max_q      <= '0;
            acc_min_q      <= CNT_SAT;
            acc_edges_q    <= '0;
            acc_ovf_q      <= 1'b0;
            acc_n_q        <= 1'b0;
            max_period_q   <= '0;
            min_period_q   <= '0;
            edge_count_q   <= '0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            win_cnt_q      <= win_cnt_d;
            cnt_q          <= cnt_d;
            seen_q         <= seen_d;
            acc_max_q      <= acc_max_d;
            acc_min_q      <= acc_min_d;
            acc_edges_q    <= acc_edges_d;
            acc_ovf_q      <= acc_ovf_d;
            acc_n_q        <= acc_n_d;
            max_period_q   <= max_period_d;
            min_period_q   <= min_period_d;
            edge_count_q   <= edge_count_d;
            overflow_q     <= overflow_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign max_period   = max_period_q;
    assign min_period   = min_period_q;
    assign edge_count   = edge_count_q;
    assign overflow     = overflow_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_period_stats.sv
// Testbench for period_stats. Two instances share clock, reset and edge
// stimulus: dut_a uses 16-bit counters, dut_b uses an 8-bit interval counter
// and a 4-bit edge counter so that interval saturation/overflow and
// edge-count saturation show up on the same edge patterns. Expected window
// results are hand-computed and queued per instance; a negedge monitor pops
// them on each result_valid and checks the outputs hold in between.

module tb_period_stats;

    localparam int WIN = 1000;

    typedef struct {
        int cyc;
        int maxp;
        int minp;
        int cnt;
        int ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        code_edge = 1'b0;

    logic [15:0] max_a, min_a, cnt_a;
    logic        ovf_a, vld_a;
    logic [7:0]  max_b, min_b;
    logic [3:0]  cnt_b;
    logic        ovf_b, vld_b;

    int   checks = 0;
    int   errors = 0;
    int   rel_cyc = 0;
    bit   mon_en = 1'b0;
    bit   clear_next = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last[2];

    period_stats #(.CNT_W(16), .WIN_CYCLES(WIN), .EDGE_W(16)) dut_a (
        .clk(clk), .rst(rst), .code_edge(code_edge),
        .max_period(max_a), .min_period(min_a), .edge_count(cnt_a),
        .overflow(ovf_a), .result_valid(vld_a)
    );

    period_stats #(.CNT_W(8), .WIN_CYCLES(WIN), .EDGE_W(4)) dut_b (
        .clk(clk), .rst(rst), .code_edge(code_edge),
        .max_period(max_b), .min_period(min_b), .edge_count(cnt_b),
        .overflow(ovf_b), .result_valid(vld_b)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, rel_cyc);
        end
    endtask

    // Queue the expected result of one window for both instances.
    task automatic expect_win(input int cyc,
                              input int mxa, input int mna, input int ca, input int oa,
                              input int mxb, input int mnb, input int cb, input int ob);
        q_a.push_back('{cyc, mxa, mna, ca, oa});
        q_b.push_back('{cyc, mxb, mnb, cb, ob});
    endtask

    // Drive code_edge for one cycle and advance to just after the edge.
    task automatic step(input logic e);
        code_edge = e;
        @(posedge clk);
        #1;
        rel_cyc++;
    endtask

    // Edges at 'first', then alternately spaced pa and pb, for n cycles.
    task automatic apply_stimulus(input int first, input int pa, input int pb, input int n);
        int nxt;
        bit alt;
        nxt = first;
        alt = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c == nxt) begin
                step(1'b1);
                nxt += alt ? pb : pa;
                alt = ~alt;
            end else begin
                step(1'b0);
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        code_edge = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel_cyc = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, "_a_max"}, 32'(max_a), 0);
        check_output({tag, "_a_min"}, 32'(min_a), 0);
        check_output({tag, "_a_count"}, 32'(cnt_a), 0);
        check_output({tag, "_a_ovf"}, 32'(ovf_a), 0);
        check_output({tag, "_a_valid"}, 32'(vld_a), 0);
        check_output({tag, "_b_max"}, 32'(max_b), 0);
        check_output({tag, "_b_min"}, 32'(min_b), 0);
        check_output({tag, "_b_count"}, 32'(cnt_b), 0);
        check_output({tag, "_b_ovf"}, 32'(ovf_b), 0);
        check_output({tag, "_b_valid"}, 32'(vld_b), 0);
    endtask

    task automatic monitor_side(input int s, input logic v, input logic [31:0] mx,
                                input logic [31:0] mn, input logic [31:0] ec, input logic ov);
        exp_t  e;
        string tag;
        int    depth;
        tag   = (s == 0) ? "a" : "b";
        depth = (s == 0) ? q_a.size() : q_b.size();
        if (v === 1'b1) begin
            if (depth == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s_unexpected_valid actual strobe at cycle %0d required none", tag, rel_cyc);
            end else begin
                if (s == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                check_output({tag, "_valid_cycle"}, rel_cyc, e.cyc);
                check_output({tag, "_max"}, mx, e.maxp);
                check_output({tag, "_min"}, mn, e.minp);
                check_output({tag, "_count"}, ec, e.cnt);
                check_output({tag, "_ovf"}, 32'(ov), e.ovf);
                last[s] = e;
            end
        end else begin
            check_output({tag, "_hold_max"}, mx, last[s].maxp);
            check_output({tag, "_hold_min"}, mn, last[s].minp);
            check_output({tag, "_hold_count"}, ec, last[s].cnt);
            check_output({tag, "_hold_ovf"}, 32'(ov), last[s].ovf);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (clear_next) begin
                last[0] = '{0, 0, 0, 0, 0};
                last[1] = '{0, 0, 0, 0, 0};
                clear_next = 1'b0;
            end
            monitor_side(0, vld_a, 32'(max_a), 32'(min_a), 32'(cnt_a), ovf_a);
            monitor_side(1, vld_b, 32'(max_b), 32'(min_b), 32'(cnt_b), ovf_b);
            if (rst) clear_next = 1'b1;
        end
    end

    initial begin
        exp_t e;
        last[0] = '{0, 0, 0, 0, 0};
        last[1] = '{0, 0, 0, 0, 0};
        rst = 1'b1;
        code_edge = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rel_cyc = 0;
        mon_en = 1'b1;
        check_zero_outputs("reset");

        $display("[TB] no edges");
        expect_win(1000, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_win(2000, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(-1, 1, 1, 2000);
        reset_dut();

        $display("[TB] periodic 100");
        expect_win(1000, 100, 100, 10, 0, 100, 100, 10, 0);
        expect_win(2000, 100, 100, 10, 0, 100, 100, 10, 0);
        apply_stimulus(5, 100, 100, 2000);
        reset_dut();

        $display("[TB] jitter 90/110");
        expect_win(1000, 110, 90, 10, 0, 110, 90, 10, 0);
        expect_win(2000, 110, 90, 10, 0, 110, 90, 10, 0);
        apply_stimulus(5, 90, 110, 2000);
        reset_dut();

        $display("[TB] back-to-back edges");
        expect_win(1000, 300, 1, 8, 0, 255, 1, 8, 1);
        apply_stimulus(10, 1, 300, 1000);
        reset_dut();

        $display("[TB] edge on close cycle");
        expect_win(1000, 500, 500, 2, 0, 255, 255, 2, 1);
        expect_win(2000, 100, 100, 1, 0, 100, 100, 1, 0);
        apply_stimulus(499, 500, 100, 1100);
        apply_stimulus(-1, 1, 1, 900);
        reset_dut();

        $display("[TB] overflow then 50-cycle spacing");
        expect_win(1000, 300, 300, 4, 0, 255, 255, 4, 1);
        expect_win(2000, 100, 50, 20, 0, 100, 50, 15, 0);
        expect_win(3000, 50, 50, 20, 0, 50, 50, 15, 0);
        apply_stimulus(5, 300, 300, 1000);
        apply_stimulus(5, 50, 50, 2000);
        reset_dut();

        $display("[TB] reset mid-window");
        expect_win(1000, 100, 100, 10, 0, 100, 100, 10, 0);
        apply_stimulus(5, 100, 100, 1600);
        reset_dut();
        check_zero_outputs("midreset");
        expect_win(1000, 200, 100, 7, 0, 200, 100, 7, 0);
        apply_stimulus(50, 200, 100, 1000);
        apply_stimulus(-1, 1, 1, 5);

        for (int i = 0; i < 20 && (q_a.size() + q_b.size()) > 0; i++) begin
            @(posedge clk);
        end
        while (q_a.size() > 0) begin
            e = q_a.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL a_missing_strobe actual none required strobe at cycle %0d", e.cyc);
        end
        while (q_b.size() > 0) begin
            e = q_b.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL b_missing_strobe actual none required strobe at cycle %0d", e.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_stats.md
# period_stats

Parametrised edge-interval statistics block for the clock-measurement path. It timestamps every `code_edge` pulse against the system clock. Over a fixed measurement window it reports the longest and shortest edge-to-edge interval, the edge count and a saturation flag. Results are registered at each window close with a one-cycle valid strobe. It supersedes the single-output maximum-period counter and adds minimum tracking, edge counting, overflow detection and explicit reset.

## Interface
Parameters:
- `CNT_W`, 16: width of the interval counter and of the `max_period`/`min_period` outputs.
- `WIN_CYCLES`, 10000: window length in clk cycles; legal range ≥ 2, < 2^24.
- `EDGE_W`, 16: width of `edge_count`.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `code_edge`  in  1  single-cycle edge pulse, already synchronous to `clk`.
- `max_period`  out  CNT_W  longest interval in the last closed window, in clk cycles.
- `min_period`  out  CNT_W  shortest interval in the last closed window, in clk cycles.
- `edge_count`  out  EDGE_W  number of `code_edge` pulses in the last closed window; saturates.
- `overflow`  out  1  set when any interval in the last closed window saturated.
- `result_valid`  out  1  one-cycle pulse, asserted in the cycle the outputs update.

## Operation
- **Window counter `win_cnt`**
  - Counts 0 to WIN_CYCLES-1, then wraps to 0.
  - A window closes on the cycle where `win_cnt == WIN_CYCLES-1`.
- **Interval counter `cnt` (CNT_W bits)**
  - On `code_edge`, loads 1. Otherwise it increments.
  - It saturates at 2^CNT_W-1 and never wraps.
  - Interval = difference of edge cycle indices: edges at cycles t0 and t1 give t1-t0.
- **`seen` flag**
  - Set by the first edge after reset.
  - An edge produces an interval sample (value = `cnt`) only when `seen` = 1.
  - The first edge after reset produces no sample.
- **Window boundaries**
  - `cnt` and `seen` are not cleared at a window close.
  - An interval spanning a boundary is credited to the window in which its terminating edge occurs.
- **Accumulators**
  - `acc_max` starts at 0. `acc_min` starts at all-ones. `acc_edges` starts at 0. `acc_ovf` starts at 0. `acc_n` (a "sample seen" flag) starts at 0.
  - Each sample updates `acc_max`/`acc_min` by comparison and sets `acc_n`.
  - A sample equal to 2^CNT_W-1 also sets `acc_ovf`.
  - Each edge increments `acc_edges`, which saturates at 2^EDGE_W-1.
- **Window close**
  - `max_period` ← `acc_max`.
  - `min_period` ← (`acc_n` ? `acc_min` : 0).
  - `edge_count` ← `acc_edges`; `overflow` ← `acc_ovf`.
  - Accumulators return to their initial values.
- **Edge on the window-close cycle**
  - The edge's sample and count are merged into the values being latched: they belong to the closing window.
  - The fresh accumulators start empty.
- **Reset** (any time, including mid-window)
  - All outputs, `result_valid`, `cnt`, `seen`, `win_cnt` and the accumulators return to initial values.
  - A partial window is discarded and no `result_valid` is produced for it.

## Timing
- All outputs are registered.
- Reset values: `max_period`=0, `min_period`=0, `edge_count`=0, `overflow`=0, `result_valid`=0.
- **First window**
  - The first cycle after `rst` deasserts has `win_cnt`=0.
  - The first close is at cycle WIN_CYCLES-1.
  - Outputs and `result_valid` are visible from cycle WIN_CYCLES and stay high for exactly one cycle.
- Windows then close every WIN_CYCLES cycles; `result_valid` period = WIN_CYCLES.
- Outputs hold their values between strobes.
- Latency from an edge to its visibility is at most WIN_CYCLES cycles.
- Back-to-back edges in consecutive cycles are legal and yield an interval of 1.

## Test plan
Cycle 0 is the first cycle after reset release.
- **Periodic, no boundary edge**
  - Setup: WIN_CYCLES=1000; edges at cycles 5, 105, …, 905, then every 100 after.
  - Window 1: `max`=100, `min`=100, `edge_count`=10, `overflow`=0, `result_valid` at cycle 1000.
  - Window 2: `max`=100, `min`=100, `edge_count`=10; the boundary-spanning interval is counted.
- **Jitter**
  - Setup: alternating intervals of 90 and 110 cycles.
  - Every full window: `max`=110, `min`=90.
- **No edges**
  - Setup: WIN_CYCLES=1000, `code_edge` held low.
  - Each window: `max`=0, `min`=0, `edge_count`=0, `overflow`=0; `result_valid` still pulses every 1000 cycles.
- **Overflow**
  - Setup: CNT_W=8; edges every 300 cycles.
  - Result: `max`=255, `min`=255, `overflow`=1.
  - Then switch to a 50-cycle spacing: `overflow`=0 once the window holds only 50-cycle intervals.
- **Edge at close**
  - Setup: edges at cycles 499 and 999 (window 1 close).
  - Window 1: `edge_count`=2, `max`=`min`=500.
  - The next edge at cycle 1099 gives window 2 `max`=`min`=100.
- **Reset mid-window**
  - Setup: assert `rst` for 1 cycle at cycle 600 of a window with edges present.
  - All outputs return to 0.
  - The next `result_valid` comes 1000 cycles after reset release.
  - The first post-reset edge produces no interval.
